// File: rtl/nexys_reset_pkg.sv
// Shared state encoding and default constants for the board reset conditioner.
package nexys_reset_pkg;

   typedef enum logic [1:0] {
      S_ASSERT   = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HOLD     = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   localparam int unsigned DEF_SYNC_STAGES  = 2;
   localparam int unsigned DEF_DEBOUNCE_CNT = 50000;
   localparam int unsigned DEF_HOLD_CNT     = 1024;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nexys_reset_conditioner_if.sv
// Bundle of the button/hold inputs and conditioned reset outputs around the conditioner.
interface nexys_reset_conditioner_if;
   logic       btn_reset_n;
   logic       hold;
   logic       rst_n;
   logic       rst_event;
   logic [1:0] state;

   modport master (output btn_reset_n, output hold,
                   input  rst_n, input rst_event, input state);
   modport slave  (input  btn_reset_n, input hold,
                   output rst_n, output rst_event, output state);
endinterface

// File: rtl/nexys_rst_sync.sv
// Multi-flop synchronizer for the raw reset button; resets to the pressed level (0).
module nexys_rst_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_sync <= '0;
      else         r_sync <= {r_sync[STAGES-2:0], d_i};
   end

   assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/nexys_reset_conditioner.sv
// Debounces the board reset button, stretches release by HOLD_CNT cycles and
// drives a registered, glitch-free active-low SoC reset.
module nexys_reset_conditioner
   import nexys_reset_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
   parameter int unsigned HOLD_CNT     = DEF_HOLD_CNT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       btn_reset_ni,
   input  logic       hold_i,
   output logic       rst_no,
   output logic       rst_event_o,
   output logic [1:0] state_o
);

   localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CNT, HOLD_CNT));
   localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CNT - 1);

   logic             w_btn_s;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rst_n;
   logic             r_event;

   nexys_rst_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (btn_reset_ni),
      .q_o    (w_btn_s)
   );

   // hold_i is tested first in every state so it always wins over button activity
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_ASSERT;
         r_cnt   <= '0;
         r_rst_n <= 1'b0;
         r_event <= 1'b0;
      end else begin
         r_event <= 1'b0;
         case (r_state)
            S_ASSERT: begin
               r_rst_n <= 1'b0;
               if (w_btn_s && !hold_i) begin
                  r_state <= S_DEBOUNCE;
                  r_cnt   <= '0;
               end
            end
            S_DEBOUNCE: begin
               if (hold_i || !w_btn_s) begin
                  r_state <= S_ASSERT;
                  r_cnt   <= '0;
               end else if (r_cnt == C_DEB_LAST) begin
                  r_state <= S_HOLD;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (hold_i || !w_btn_s) begin
                  r_state <= S_ASSERT;
                  r_cnt   <= '0;
               end else if (r_cnt == C_HOLD_LAST) begin
                  r_state <= S_RUN;
                  r_cnt   <= '0;
                  r_rst_n <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (hold_i || (!w_btn_s && r_cnt == C_DEB_LAST)) begin
                  r_state <= S_ASSERT;
                  r_cnt   <= '0;
                  r_rst_n <= 1'b0;
                  r_event <= 1'b1;
               end else if (!w_btn_s) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else begin
                  r_cnt <= '0;
               end
            end
            default: begin
               r_state <= S_ASSERT;
               r_cnt   <= '0;
               r_rst_n <= 1'b0;
            end
         endcase
      end
   end

   assign rst_no      = r_rst_n;
   assign rst_event_o = r_event;
   assign state_o     = r_state;

endmodule

// File: tb/tb_nexys_reset_conditioner.sv
// Bench for nexys_reset_conditioner with SYNC_STAGES=2, DEBOUNCE_CNT=4, HOLD_CNT=8.
module tb_nexys_reset_conditioner;
   import nexys_reset_pkg::*;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;
   localparam int unsigned HLD  = 8;
   localparam int PWR_EDGES = SYNC + 1 + DEB + HLD;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   nexys_reset_conditioner_if u_if ();

   always #5 clk = ~clk;

   nexys_reset_conditioner #(
      .SYNC_STAGES  (SYNC),
      .DEBOUNCE_CNT (DEB),
      .HOLD_CNT     (HLD)
   ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .btn_reset_ni (u_if.btn_reset_n),
      .hold_i       (u_if.hold),
      .rst_no       (u_if.rst_n),
      .rst_event_o  (u_if.rst_event),
      .state_o      (u_if.state)
   );

   typedef struct {
      int         edge_no;
      logic       rst_n;
      logic       ev;
      logic       chk_state;
      logic [1:0] state;
   } exp_t;

   // Edges counted from the first rising edge of the vector; -1/0 mean "none".
   typedef struct {
      int         low_start;
      int         low_len;
      int         hold_at;
      int         n_edges;
      int         fall_edge;
      int         rise_edge;
      int         probe_edge;
      logic [1:0] probe_state;
   } vec_t;

   exp_t  exp_q[$];
   vec_t  vecs[6];
   string vnames[6];

   task automatic check(input string nm, input logic [1:0] act, input logic [1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got empty scoreboard, expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("%s e%0d rst_no", tag, e.edge_no), {1'b0, u_if.rst_n}, {1'b0, e.rst_n});
         check($sformatf("%s e%0d rst_event", tag, e.edge_no), {1'b0, u_if.rst_event}, {1'b0, e.ev});
         if (e.chk_state)
            check($sformatf("%s e%0d state", tag, e.edge_no), u_if.state, e.state);
      end
   endtask

   task automatic power_up(input string tag);
      exp_t e;
      for (int k = 1; k <= PWR_EDGES + 2; k++) begin
         e.edge_no   = k;
         e.rst_n     = (k >= PWR_EDGES);
         e.ev        = 1'b0;
         e.chk_state = 1'b1;
         if (k < int'(SYNC) + 1)                   e.state = S_ASSERT;
         else if (k < int'(SYNC) + 1 + int'(DEB))  e.state = S_DEBOUNCE;
         else if (k < PWR_EDGES)                   e.state = S_HOLD;
         else                                      e.state = S_RUN;
         exp_q.push_back(e);
      end
      @(negedge clk);
      u_if.btn_reset_n = 1'b1;
      u_if.hold        = 1'b0;
      rst_n            = 1'b1;
      for (int k = 1; k <= PWR_EDGES + 2; k++) begin
         @(posedge clk);
         #1;
         pop_check(tag);
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      exp_t e;
      v = vecs[i];
      for (int k = 1; k <= v.n_edges; k++) begin
         e.edge_no   = k;
         e.rst_n     = (v.fall_edge < 0) ? 1'b1 : ((k < v.fall_edge) || (k >= v.rise_edge));
         e.ev        = (k == v.fall_edge);
         e.chk_state = (k == v.fall_edge) || (k == v.rise_edge) || (k == v.probe_edge);
         if (k == v.probe_edge)     e.state = v.probe_state;
         else if (k == v.fall_edge) e.state = S_ASSERT;
         else                       e.state = S_RUN;
         exp_q.push_back(e);
      end
      for (int k = 1; k <= v.n_edges; k++) begin
         @(negedge clk);
         u_if.btn_reset_n = !((k >= v.low_start) && (k < v.low_start + v.low_len));
         u_if.hold        = (k == v.hold_at);
         @(posedge clk);
         #1;
         pop_check(vnames[i]);
      end
   endtask

   initial begin
      vnames[0] = "short_press";  vecs[0] = '{1, 3,  0, 12, -1, -1, 12, S_RUN};
      vnames[1] = "press_eq_deb"; vecs[1] = '{1, 4,  0, 21,  6, 19,  7, S_DEBOUNCE};
      vnames[2] = "long_press";   vecs[2] = '{1, 10, 0, 27,  6, 25, 11, S_ASSERT};
      vnames[3] = "hold_pulse";   vecs[3] = '{0, 0,  1, 16,  1, 14,  2, S_DEBOUNCE};
      vnames[4] = "hold_in_press"; vecs[4] = '{1, 10, 3, 27, 3, 25,  6, S_ASSERT};
      vnames[5] = "glitch_hold5"; vecs[5] = '{12, 1, 1, 29,  1, 27, 14, S_ASSERT};

      u_if.btn_reset_n = 1'b1;
      u_if.hold        = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset rst_no", {1'b0, u_if.rst_n}, 2'd0);
      check("reset rst_event", {1'b0, u_if.rst_event}, 2'd0);
      check("reset state", u_if.state, S_ASSERT);

      power_up("powerup");
      for (int i = 0; i < 6; i++) run_vec(i);

      // Asynchronous reset in the middle of an S_RUN cycle
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async rst_no", {1'b0, u_if.rst_n}, 2'd0);
      check("async rst_event", {1'b0, u_if.rst_event}, 2'd0);
      check("async state", u_if.state, S_ASSERT);
      @(posedge clk);
      #1;
      check("async held rst_event", {1'b0, u_if.rst_event}, 2'd0);
      check("async held rst_no", {1'b0, u_if.rst_n}, 2'd0);

      power_up("repowerup");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nexys_reset_conditioner.md
NEXYS_RESET_CONDITIONER -- requirements
Module: nexys_reset_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on the button input (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 50000, consecutive stable cycles required to accept a button level change (legal minimum 2).
REQ-003 SHALL have parameter HOLD_CNT, default 1024, extra cycles the reset is held after debounced release (legal minimum 2).
REQ-004 SHALL have port clk_i, input, width 1, the board reference clock after the input clock buffer; the block uses one clock.
REQ-005 SHALL have port rst_ni, input, width 1, asynchronous active-low power-on reset.
REQ-006 SHALL have port btn_reset_ni, input, width 1, raw asynchronous board reset button; 0 means pressed.
REQ-007 SHALL have port hold_i, input, width 1, active-high synchronous hold request, e.g. clock not locked.
REQ-008 SHALL have port rst_no, output, width 1, conditioned active-low reset that drives the SoC pad_reset_n.
REQ-009 SHALL have port rst_event_o, output, width 1, one-cycle pulse each time the block leaves S_RUN.
REQ-010 SHALL have port state_o, output, width 2, current FSM state for debug.

Function
REQ-011 SHALL pass btn_reset_ni through SYNC_STAGES flops; only the last stage (btn_s) is used by the FSM.
REQ-012 SHALL implement states S_ASSERT, S_DEBOUNCE, S_HOLD and S_RUN, with one shared counter cnt of width $clog2(max(DEBOUNCE_CNT,HOLD_CNT)).
REQ-013 S_ASSERT: rst_no=0; if btn_s=1 and hold_i=0, go to S_DEBOUNCE with cnt=0; otherwise stay.
REQ-014 S_DEBOUNCE: rst_no=0; if btn_s=0 or hold_i=1, go to S_ASSERT with cnt=0; else if cnt==DEBOUNCE_CNT-1, go to S_HOLD with cnt=0; else increment cnt.
REQ-015 S_HOLD: rst_no=0; if btn_s=0 or hold_i=1, go to S_ASSERT with cnt=0; else if cnt==HOLD_CNT-1, go to S_RUN with cnt=0; else increment cnt.
REQ-016 S_RUN: rst_no=1.
  - hold_i=1 goes to S_ASSERT immediately, with no filtering.
  - btn_s=0 increments cnt; btn_s=1 clears cnt.
  - When btn_s=0 and cnt==DEBOUNCE_CNT-1, go to S_ASSERT.
REQ-017 rst_no SHALL be a flop: set on the edge entering S_RUN, cleared on the edge leaving it; it SHALL be glitch-free and have no combinational path from any input.
REQ-018 rst_event_o SHALL be high for exactly the one cycle after the edge S_RUN->S_ASSERT, otherwise 0.
REQ-019 With btn_s stable at 1 and hold_i=0 from reset release, rst_no SHALL rise on rising edge SYNC_STAGES+1+DEBOUNCE_CNT+HOLD_CNT after rst_ni deasserts.
REQ-020 Any press shorter than DEBOUNCE_CNT cycles in S_RUN SHALL be ignored, with rst_no kept at 1.
REQ-021 cnt SHALL never wrap; it saturates at its terminal compare value by construction of REQ-014 to REQ-016.
REQ-022 When hold_i and a button event occur in the same cycle, hold_i SHALL take priority; the result is the same next state (S_ASSERT).

Reset
REQ-023 rst_ni=0 SHALL asynchronously force:
  - state to S_ASSERT, cnt to 0, all synchronizer flops to 0 (pressed);
  - rst_no=0, rst_event_o=0, state_o=S_ASSERT encoding.
REQ-024 rst_ni asserted mid-operation, including in S_RUN, SHALL drop rst_no within the same cycle and SHALL NOT pulse rst_event_o.
REQ-025 Deassertion of rst_ni SHALL restart the full sequence of REQ-019.

Structure
REQ-026 Package nexys_reset_pkg SHALL hold the state enum (2-bit: S_ASSERT=0, S_DEBOUNCE=1, S_HOLD=2, S_RUN=3) and the default parameter constants.
REQ-027 The synchronizer SHALL be the sub-module nexys_rst_sync (parameter STAGES, async active-low reset to 0), marked ASYNC_REG for implementation.
REQ-028 No vendor primitives SHALL be instantiated; the top-level FPGA wrapper connects rst_no to the SoC reset pad input.

Verification (SYNC_STAGES=2, DEBOUNCE_CNT=4, HOLD_CNT=8)
REQ-029 Release rst_ni with button high and hold_i=0 -> rst_no=0 through edge 14, rst_no=1 at edge 15, state_o=3.
REQ-030 In S_RUN, drive btn_reset_ni low for 3 cycles, then high -> rst_no stays 1, no rst_event_o pulse.
REQ-031 In S_RUN, drive btn_reset_ni low for 10 cycles -> rst_no falls 2+4 edges after the press, one rst_event_o pulse; on release, rst_no rises 2+1+4+8 edges later.
REQ-032 In S_HOLD (cnt=5), pulse button low for 1 cycle -> return to S_ASSERT, full debounce+hold sequence restarts from cnt=0.
REQ-033 In S_RUN, raise hold_i for 1 cycle -> rst_no=0 next edge, rst_event_o pulses once; with hold_i low, rst_no returns after 1+4+8 edges.
REQ-034 Assert rst_ni asynchronously mid-cycle in S_RUN -> rst_no=0 immediately, rst_event_o=0, state_o=0.
